// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wb_en
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_FIN  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_FIX  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [4:0]        rd_lat_q, rd_lat_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic              done_q, done_d;

    logic              accept;
    logic              sa_in, sb_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div0, ovf;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     madd;
    logic [XLEN:0]     rsh, diff;
    logic              ge;
    logic [2*XLEN-1:0] mul_next, div_next, prod_neg;
    logic [XLEN-1:0]   quo, rem, fin_res;

    assign busy   = (state_q == S_CALC) || (state_q == S_FIN) || (state_q == S_FIX);
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;
    assign wb_en  = done_q && (rd_out_q != 5'd0);
    assign accept = start && !busy && !flush;

    always_comb begin
        sa_in = 1'b0;
        sb_in = 1'b0;
        case (funct3)
            3'd1, 3'd4, 3'd6: begin sa_in = rs1_data[XLEN-1]; sb_in = rs2_data[XLEN-1]; end
            3'd2:             sa_in = rs1_data[XLEN-1];
            default: ;
        endcase
        a_mag = sa_in ? -rs1_data : rs1_data;
        b_mag = sb_in ? -rs2_data : rs2_data;

        div0 = funct3[2] && (rs2_data == '0);
        ovf  = funct3[2] && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
               && (rs2_data == '1);
        if (div0) special_res = funct3[1] ? rs1_data : '1;
        else      special_res = funct3[1] ? '0 : rs1_data;

        // Multiply: {hi, multiplier} shifts right; hi accumulates the multiplicand.
        madd     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {madd, prod_q[XLEN-1:1]};

        // Divide: {remainder, dividend/quotient} shifts left; quotient bits enter at LSB.
        rsh      = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        diff     = rsh - {1'b0, mcand_q};
        ge       = !diff[XLEN];
        div_next = {(ge ? diff[XLEN-1:0] : rsh[XLEN-1:0]), prod_q[XLEN-2:0], ge};

        prod_neg = -prod_q;
        quo = (sa_q ^ sb_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem = sa_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        if (f3_q[2])
            fin_res = f3_q[1] ? rem : quo;
        else if (f3_q == 3'd0)
            fin_res = prod_q[XLEN-1:0];
        else
            fin_res = (sa_q ^ sb_q) ? prod_neg[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        rd_lat_d = rd_lat_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    f3_d     = funct3;
                    sa_d     = sa_in;
                    sb_d     = sb_in;
                    rd_lat_d = rd_in;
                    cnt_d    = '0;
                    if (div0 || ovf) begin
                        prod_d  = {{XLEN{1'b0}}, special_res};
                        state_d = S_FIX;
                    end else begin
                        prod_d  = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                        mcand_d = funct3[2] ? b_mag : a_mag;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                prod_d = f3_q[2] ? div_next : mul_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1))
                    state_d = S_FIN;
            end
            S_FIN: begin
                result_d = fin_res;
                rd_out_d = rd_lat_q;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            S_FIX: begin
                result_d = prod_q[XLEN-1:0];
                rd_out_d = rd_lat_q;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // An aborted op must leave the last completed result untouched.
        if (flush) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            rd_lat_q <= '0;
            result_q <= '0;
            rd_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            rd_lat_q <= rd_lat_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - vector table plus scoreboard bench for muldiv_unit
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, wb_en;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[12];
    logic [36:0] sbq[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 200);
        check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int lat);
        int n;
        logic [36:0] item;
        sbq.push_back({rd, exp});
        issue(f3, a, b, rd);
        wait_done(n);
        check("latency", 32'(n + 1), 32'(lat));
        item = sbq.pop_front();
        check("result", result, item[31:0]);
        check("rd_out", {27'd0, rd_out}, {27'd0, item[36:32]});
        check("wb_en", {31'd0, wb_en}, {31'd0, item[36:32] != 5'd0});
        @(posedge clk);
        #1;
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int cnt;
        logic [36:0] item;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34};
        vecs[1]  = '{3'd1, 32'h80000000,   32'h80000000, 5'd6,  32'h40000000, 34};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 34};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,        5'd11, 32'd14,       34};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,        5'd12, 32'd2,        34};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,        5'd13, 32'hFFFFFFFF, 2};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,        5'd14, 32'd5,        2};
        vecs[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd15, 32'h80000000, 2};
        vecs[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd31, 32'd0,        2};

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

        // start pulsed during CALC must be ignored
        sbq.push_back({5'd7, 32'hFFFFFFFE});
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("ignored_start_latency", 32'(n + 7), 32'd34);
        item = sbq.pop_front();
        check("ignored_start_result", result, item[31:0]);
        check("ignored_start_rd", {27'd0, rd_out}, {27'd0, item[36:32]});
        count_dones(50, cnt);
        check("ignored_start_extra_done", 32'(cnt), 32'd0);

        // flush at cycle 10 of CALC
        issue(3'd5, 32'd1000, 32'd10, 5'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        count_dones(40, cnt);
        check("flush_no_done", 32'(cnt), 32'd0);
        check("flush_result_kept", result, 32'hFFFFFFFE);
        check("flush_rd_kept", {27'd0, rd_out}, 32'd7);
        run_op(3'd5, 32'd1000, 32'd10, 5'd3, 32'd100, 34);

        // reset mid-CALC
        issue(3'd0, 32'd5, 32'd6, 5'd4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        count_dones(40, cnt);
        check("midreset_no_done", 32'(cnt), 32'd0);
        run_op(3'd0, 32'd5, 32'd6, 5'd0, 32'd30, 34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
